// File: rtl/pconv_mc.sv
// Multi-input-channel pointwise (1x1) convolution engine: IN_CH beats per pixel into OUT_CH MACs,
// then bias, rounded shift and saturation. Define PCONV_MC_RELU_EN to fuse a ReLU after saturation.
module pconv_mc #(
    parameter int N        = 16,
    parameter int ACC_W    = 32,
    parameter int IN_CH    = 3,
    parameter int OUT_CH   = 32,
    parameter int IMG_SIZE = 6,
    localparam int CH_W    = (IN_CH > 1) ? $clog2(IN_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    in_vld,
    input  logic [N-1:0]            in_din,
    input  logic [OUT_CH*N-1:0]     weight_din,
    input  logic [OUT_CH*ACC_W-1:0] bias_din,
    input  logic [OUT_CH*5-1:0]     shift_din,
    output logic [CH_W-1:0]         ch_idx,
    output logic [OUT_CH*N-1:0]     conv_dout,
    output logic                    conv_vld,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int PIX   = IMG_SIZE * IMG_SIZE;
    localparam int PIX_W = (PIX > 1) ? $clog2(PIX) : 1;
    // Two guard bits keep acc+bias plus the rounding term exact before the clamp.
    localparam int SW    = ACC_W + 2;
    localparam logic signed [SW-1:0] SAT_HI = $signed((SW'(1'b1) << (N - 1)) - SW'(1'b1));
`ifdef PCONV_MC_RELU_EN
    localparam logic signed [SW-1:0] SAT_LO = '0;
`else
    localparam logic signed [SW-1:0] SAT_LO = $signed(~((SW'(1'b1) << (N - 1)) - SW'(1'b1)));
`endif

    logic [ACC_W-1:0]        acc_r     [OUT_CH];
    logic signed [2*N-1:0]   mul_s     [OUT_CH];
    logic [ACC_W-1:0]        sum_s     [OUT_CH];
    logic [ACC_W-1:0]        s1_acc_r  [OUT_CH];
    logic [ACC_W-1:0]        s1_bias_r [OUT_CH];
    logic [4:0]              s1_shift_r[OUT_CH];
    logic signed [SW-1:0]    s_s       [OUT_CH];
    logic signed [SW-1:0]    rnd_s     [OUT_CH];
    logic signed [SW-1:0]    t_s       [OUT_CH];
    logic [N-1:0]            res_s     [OUT_CH];
    logic                    s1_vld_r;
    logic [CH_W-1:0]         ch_idx_r;
    logic [PIX_W-1:0]        pix_cnt_r;
    logic [OUT_CH*N-1:0]     conv_dout_r;
    logic                    conv_vld_r;
    logic                    frame_done_r;
    logic                    busy_r;
    logic                    beat_s;
    logic                    last_s;

    assign beat_s = ce & in_vld;
    assign last_s = beat_s & (ch_idx_r == CH_W'(IN_CH - 1));

    // Per-output-channel product and running sum for the current beat.
    always_comb begin
        for (int o = 0; o < OUT_CH; o++) begin
            mul_s[o] = $signed(in_din) * $signed(weight_din[o*N +: N]);
            sum_s[o] = acc_r[o] + ACC_W'(mul_s[o]);
        end
    end

    // Stage 2 arithmetic: bias add, round-half-up shift, clamp.
    always_comb begin
        for (int o = 0; o < OUT_CH; o++) begin
            s_s[o]   = SW'($signed(s1_acc_r[o])) + SW'($signed(s1_bias_r[o]));
            rnd_s[o] = '0;
            t_s[o]   = s_s[o];
            if (s1_shift_r[o] != 5'd0) begin
                rnd_s[o] = $signed(SW'(1'b1) << (s1_shift_r[o] - 5'd1));
                t_s[o]   = (s_s[o] + rnd_s[o]) >>> s1_shift_r[o];
            end else begin
                t_s[o]   = s_s[o];
            end
            if (t_s[o] > SAT_HI) begin
                res_s[o] = SAT_HI[N-1:0];
            end else if (t_s[o] < SAT_LO) begin
                res_s[o] = SAT_LO[N-1:0];
            end else begin
                res_s[o] = t_s[o][N-1:0];
            end
        end
    end

    // Accumulator, channel index, two pipeline stages and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < OUT_CH; o++) begin
                acc_r[o]      <= '0;
                s1_acc_r[o]   <= '0;
                s1_bias_r[o]  <= '0;
                s1_shift_r[o] <= 5'd0;
            end
            s1_vld_r     <= 1'b0;
            ch_idx_r     <= '0;
            pix_cnt_r    <= '0;
            conv_dout_r  <= '0;
            conv_vld_r   <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else if (ce) begin
            if (beat_s) begin
                ch_idx_r <= last_s ? '0 : ch_idx_r + CH_W'(1);
                for (int o = 0; o < OUT_CH; o++) begin
                    acc_r[o] <= last_s ? '0 : sum_s[o];
                end
            end
            s1_vld_r <= last_s;
            if (last_s) begin
                for (int o = 0; o < OUT_CH; o++) begin
                    s1_acc_r[o]   <= sum_s[o];
                    s1_bias_r[o]  <= bias_din[o*ACC_W +: ACC_W];
                    s1_shift_r[o] <= shift_din[o*5 +: 5];
                end
            end
            conv_vld_r   <= s1_vld_r;
            frame_done_r <= s1_vld_r && (pix_cnt_r == PIX_W'(PIX - 1));
            if (s1_vld_r) begin
                for (int o = 0; o < OUT_CH; o++) begin
                    conv_dout_r[o*N +: N] <= res_s[o];
                end
                pix_cnt_r <= (pix_cnt_r == PIX_W'(PIX - 1)) ? '0 : pix_cnt_r + PIX_W'(1);
            end
            // A beat arriving in the frame_done cycle keeps busy high.
            if (beat_s) begin
                busy_r <= 1'b1;
            end else if (frame_done_r) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign ch_idx     = ch_idx_r;
    assign conv_dout  = conv_dout_r;
    assign busy       = busy_r;
    // Held pulses stay pending through a stall and surface once ce returns.
    assign conv_vld   = conv_vld_r & ce;
    assign frame_done = frame_done_r & ce;

endmodule
